// File: rtl/adc_spi_reader.sv
// rtl/adc_spi_reader.sv - SPI frame reader for a 12-bit serial ADC
// One accepted start runs a 16-SCLK frame: channel bits out on din, 16 bits in, low 12 kept.
module adc_spi_reader #(
  parameter int CLK_DIV = 25
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  channel,
  output logic        adc_cs_n,
  output logic        adc_sclk,
  output logic        adc_din,
  input  logic        adc_sdo,
  output logic [11:0] adc_dout,
  output logic        data_valid,
  output logic        busy
);
  localparam int CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;
  state_t state, state_nxt;

  logic [CW-1:0] half_cnt;
  logic [3:0]    bit_cnt;
  logic          sclk_q;
  logic          din_q;
  logic [2:0]    ch_q;
  logic [11:0]   shift_q;
  logic [11:0]   dout_q;

  logic          half_end;
  logic          sclk_rise;
  logic          sclk_fall;
  logic [3:0]    next_period;
  logic          period_bit;

  assign half_end = (half_cnt == HALF_LAST);

  always_comb begin
    state_nxt   = state;
    sclk_rise   = 1'b0;
    sclk_fall   = 1'b0;
    next_period = 4'd0;
    case (state)
      IDLE: begin
        if (start) state_nxt = SETUP;
      end
      SETUP: begin
        if (half_end) begin
          state_nxt = SHIFT;
          sclk_fall = 1'b1;
        end
      end
      SHIFT: begin
        if (half_end) begin
          if (!sclk_q) begin
            sclk_rise = 1'b1;
          end else if (bit_cnt == 4'd15) begin
            state_nxt = HOLD;
          end else begin
            sclk_fall   = 1'b1;
            next_period = bit_cnt + 4'd1;
          end
        end
      end
      HOLD: begin
        if (half_end) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // next_period is zero-based: index 2..4 are SCLK periods 3..5 carrying the channel
  always_comb begin
    period_bit = 1'b0;
    case (next_period)
      4'd2:    period_bit = ch_q[2];
      4'd3:    period_bit = ch_q[1];
      4'd4:    period_bit = ch_q[0];
      default: period_bit = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      half_cnt <= '0;
      bit_cnt  <= 4'd0;
      sclk_q   <= 1'b1;
      din_q    <= 1'b0;
      ch_q     <= 3'd0;
      shift_q  <= 12'd0;
      dout_q   <= 12'd0;
    end else begin
      state <= state_nxt;
      if (state == IDLE || state == DONE || half_end) begin
        half_cnt <= '0;
      end else begin
        half_cnt <= half_cnt + CW'(1);
      end
      if (state == IDLE && start) ch_q <= channel;
      if (sclk_fall) begin
        sclk_q <= 1'b0;
        din_q  <= period_bit;
      end
      // 16 samples go through a 12-bit register, so the ADC's leading nibble falls off the top
      if (sclk_rise) begin
        sclk_q  <= 1'b1;
        shift_q <= {shift_q[10:0], adc_sdo};
      end
      if (state == SHIFT && half_end && sclk_q) begin
        bit_cnt <= (bit_cnt == 4'd15) ? 4'd0 : bit_cnt + 4'd1;
      end
      if (state == HOLD && half_end) dout_q <= shift_q;
    end
  end

  assign adc_cs_n   = (state == IDLE) || (state == DONE);
  assign adc_sclk   = sclk_q;
  assign adc_din    = din_q;
  assign adc_dout   = dout_q;
  assign data_valid = (state == DONE);
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_adc_spi_reader.sv
// tb/tb_adc_spi_reader.sv - self-checking bench for adc_spi_reader
// Behavioural ADC slave plus frame-level expectations for CLK_DIV=2 and CLK_DIV=1 instances.
module tb_adc_spi_reader;
  localparam int D = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  channel = 3'd0;
  logic        sdo = 1'b0;
  logic        cs_n, sclk, din, valid, busy;
  logic [11:0] dout;

  logic        start1 = 1'b0;
  logic [2:0]  ch1 = 3'd0;
  logic        sdo1 = 1'b1;
  logic        cs_n1, sclk1, din1, valid1, busy1;
  logic [11:0] dout1;

  adc_spi_reader #(.CLK_DIV(D)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .channel(channel),
    .adc_cs_n(cs_n), .adc_sclk(sclk), .adc_din(din), .adc_sdo(sdo),
    .adc_dout(dout), .data_valid(valid), .busy(busy)
  );

  adc_spi_reader #(.CLK_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .channel(ch1),
    .adc_cs_n(cs_n1), .adc_sclk(sclk1), .adc_din(din1), .adc_sdo(sdo1),
    .adc_dout(dout1), .data_valid(valid1), .busy(busy1)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ADC slave: loads a word on CS fall, presents the next bit on each SCLK fall
  logic [15:0] word_q[$];
  logic [15:0] adc_word = 16'h0;
  logic [15:0] din_vec = 16'h0;
  int fall_idx = 0, rise_idx = 0, low_len = 0, bad_width = 0;
  logic prev_cs = 1'b1, prev_sclk = 1'b1;

  always @(negedge clk) begin
    if (prev_cs && !cs_n) begin
      adc_word = 16'h0;
      if (word_q.size() > 0) adc_word = word_q.pop_front();
      fall_idx = 0;
      rise_idx = 0;
      low_len  = 0;
      din_vec  = 16'h0;
    end
    if (!cs_n) begin
      if (prev_sclk && !sclk && fall_idx < 16) begin
        sdo = adc_word[15 - fall_idx];
        fall_idx++;
      end
      if (!sclk) low_len++;
      if (!prev_sclk && sclk) begin
        if (low_len != D) bad_width++;
        low_len = 0;
        rise_idx++;
        din_vec = {din_vec[14:0], din};
      end
    end
    prev_cs   = cs_n;
    prev_sclk = sclk;
  end

  function automatic logic [11:0] ref_dout(input logic [15:0] w);
    return w[11:0];
  endfunction

  // din per SCLK period, period 1 in the MSB
  function automatic logic [15:0] ref_din(input logic [2:0] ch);
    logic [15:0] v = 16'h0;
    for (int p = 1; p <= 16; p++) begin
      if (p == 3) v[16-p] = ch[2];
      else if (p == 4) v[16-p] = ch[1];
      else if (p == 5) v[16-p] = ch[0];
    end
    return v;
  endfunction

  task automatic run_frame(input string tag, input logic [2:0] ch, input logic [15:0] word,
                           input logic [11:0] exp_dout, input logic [15:0] exp_din,
                           input int restart_at);
    int first_k = -1;
    int nvalid = 0;
    int bw0 = bad_width;
    logic [11:0] seen = 12'h0;
    word_q.push_back(word);
    channel = ch;
    start = 1'b1;
    for (int k = 1; k <= 34*D + 12; k++) begin
      @(posedge clk); @(negedge clk);
      start = 1'b0;
      if (k == restart_at) begin
        start = 1'b1;
        channel = ~ch;
      end
      if (k == 1) check({tag, " setup cs/sclk/busy"}, int'({cs_n, sclk, busy}), 3);
      if (valid) begin
        nvalid++;
        if (first_k < 0) begin
          first_k = k;
          seen = dout;
        end
      end
    end
    check({tag, " latency"}, first_k, 34*D + 1);
    check({tag, " valid count"}, nvalid, 1);
    check({tag, " dout"}, int'(seen), int'(exp_dout));
    check({tag, " dout held"}, int'(dout), int'(exp_dout));
    check({tag, " din periods"}, int'(din_vec), int'(exp_din));
    check({tag, " sclk rises"}, rise_idx, 16);
    check({tag, " low width"}, bad_width - bw0, 0);
    check({tag, " idle after"}, int'({busy, cs_n}), 1);
  endtask

  typedef struct {
    logic [2:0]  ch;
    logic [15:0] word;
    logic [11:0] exp_dout;
    logic [15:0] exp_din;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int nv, k1, k2, k3;
    logic [11:0] d1, d2, d3;

    vecs[0] = '{3'd5, 16'h0DDE, 12'hDDE, 16'h2800};
    vecs[1] = '{3'd3, 16'hF123, 12'h123, 16'h1800};
    vecs[2] = '{3'd0, 16'hFFFF, 12'hFFF, 16'h0000};
    vecs[3] = '{3'd7, 16'h0000, 12'h000, 16'h3800};
    vecs[4] = '{3'd2, 16'h8001, 12'h001, 16'h1000};

    // reset, with start high while held in reset
    rst_n = 1'b0; start = 1'b1; start1 = 1'b1; channel = 3'd5;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst cs_n", int'(cs_n), 1);
    check("rst sclk", int'(sclk), 1);
    check("rst din", int'(din), 0);
    check("rst dout", int'(dout), 0);
    check("rst valid", int'(valid), 0);
    check("rst busy", int'(busy), 0);
    rst_n = 1'b1; start = 1'b0; start1 = 1'b0;
    @(posedge clk); @(negedge clk);
    check("post-rst busy", int'(busy), 0);

    for (int i = 0; i < 5; i++)
      run_frame($sformatf("vec%0d", i), vecs[i].ch, vecs[i].word, vecs[i].exp_dout,
                vecs[i].exp_din, 0);

    for (int i = 0; i < 6; i++) begin
      logic [2:0]  rch = 3'($urandom_range(0, 7));
      logic [15:0] rw  = 16'($urandom);
      run_frame($sformatf("rand%0d", i), rch, rw, ref_dout(rw), ref_din(rch), 0);
    end

    run_frame("restart", 3'b110, 16'h0ABC, 12'hABC, 16'h3000, 10);

    // reset in the middle of a frame
    word_q.push_back(16'h0555);
    channel = 3'd1; start = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    check("abort cs_n", int'(cs_n), 1);
    check("abort sclk", int'(sclk), 1);
    check("abort busy", int'(busy), 0);
    check("abort dout", int'(dout), 0);
    rst_n = 1'b1;
    nv = 0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); @(negedge clk);
      if (valid) nv++;
    end
    check("abort no valid", nv, 0);
    check("abort dout kept", int'(dout), 0);

    // start held high across three frames
    word_q.push_back(16'd3550); word_q.push_back(16'd3600); word_q.push_back(16'd3700);
    channel = 3'd4; start = 1'b1;
    nv = 0; k1 = -1; k2 = -1; k3 = -1; d1 = 0; d2 = 0; d3 = 0;
    for (int k = 1; k <= 3*(34*D + 2) + 10; k++) begin
      @(posedge clk); @(negedge clk);
      if (valid) begin
        nv++;
        if (nv == 1) begin k1 = k; d1 = dout; end
        if (nv == 2) begin k2 = k; d2 = dout; end
        if (nv == 3) begin k3 = k; d3 = dout; start = 1'b0; end
      end
    end
    start = 1'b0;
    check("b2b count", nv, 3);
    check("b2b first", k1, 34*D + 1);
    check("b2b gap1", k2 - k1, 34*D + 2);
    check("b2b gap2", k3 - k2, 34*D + 2);
    check("b2b dout1", int'(d1), 3550);
    check("b2b dout2", int'(d2), 3600);
    check("b2b dout3", int'(d3), 3700);

    // CLK_DIV=1 instance: SCLK shape and latency
    begin
      int nlow = 0, badw = 0, low_run = 0, first_low = -1, last_low = -1, vk = -1, nv1 = 0;
      start1 = 1'b1;
      for (int k = 1; k <= 45; k++) begin
        @(posedge clk); @(negedge clk);
        start1 = 1'b0;
        if (!sclk1) begin
          low_run++;
          if (first_low < 0) first_low = k;
          last_low = k;
        end else if (low_run > 0) begin
          nlow++;
          if (low_run != 1) badw++;
          low_run = 0;
        end
        if (valid1) begin
          nv1++;
          if (vk < 0) vk = k;
        end
      end
      check("div1 low pulses", nlow, 16);
      check("div1 low width", badw, 0);
      check("div1 first low", first_low, 2);
      check("div1 last low", last_low, 32);
      check("div1 latency", vk, 35);
      check("div1 valid count", nv1, 1);
      check("div1 dout", int'(dout1), 12'hFFF);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
